fifo_wr_arbiter: RTL

- Round-robin write-side arbiter that shares the single write port of the team's synchronous FIFO among NREQ requesters.
- A winner holds the port for a burst of up to MAXBURST words, so a packet from one source is not interleaved with another source's data.
- Sits directly in front of the FIFO's wr/dataIn/full pins. The read side and the FIFO's en are owned elsewhere; en is held high whenever this block writes.

---
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port signals of the write arbiter
interface fifo_wr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        last;
  logic [NREQ*DWIDTH-1:0] din;
  logic [NREQ-1:0]        ack;
  logic [IW-1:0]          owner;
  logic                   busy;
  logic                   fifo_full;
  logic                   fifo_wr;
  logic [DWIDTH-1:0]      fifo_din;

  // master: requesters plus the FIFO full flag; slave: the arbiter itself
  modport master (
    output req, last, din, fifo_full,
    input  ack, owner, busy, fifo_wr, fifo_din
  );

  modport slave (
    input  req, last, din, fifo_full,
    output ack, owner, busy, fifo_wr, fifo_din
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = 8,
  parameter int MAXBURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic [IW-1:0] winner;
  logic [IW-1:0] owner_inc;
  logic          found;
  logic          busy;
  logic          accept;
  logic          burst_end;

  // first requester at or above rr_ptr, wrapping modulo NREQ (NREQ need not be 2^n)
  always_comb begin : pick
    int idx;
    idx    = 0;
    winner = rr_ptr_q;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign owner_inc = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign busy      = (state_q == BURST);
  assign accept    = busy && bus.req[owner_q] && !bus.fifo_full;
  assign burst_end = busy && (!bus.req[owner_q] ||
                     (accept && (bus.last[owner_q] || burst_cnt_q == 8'(MAXBURST - 1))));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = BURST;
          owner_d     = winner;
          burst_cnt_d = 8'd0;
        end
      end
      BURST: begin
        if (accept) burst_cnt_d = burst_cnt_q + 8'd1;
        if (burst_end) begin
          state_d  = IDLE;
          rr_ptr_d = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // zero-latency handshake: outputs depend on registered owner/state and live inputs
  always_comb begin
    bus.ack          = '0;
    bus.ack[owner_q] = accept;
    bus.fifo_wr      = accept;
    bus.busy         = busy;
    bus.owner        = owner_q;
    bus.fifo_din     = busy ? bus.din[int'(owner_q)*DWIDTH +: DWIDTH] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
endmodule
